// File: rtl/secded_pkg.sv
// Shared types and sizing helpers for the SECDED batch engine and its codec.
package secded_pkg;

   typedef enum logic [2:0] {st_idle, st_rd, st_calc, st_wr, st_done} state_e;

   typedef enum logic [1:0] {
      stat_ok     = 2'b00,
      stat_single = 2'b01,
      stat_double = 2'b10
   } status_e;

   // Hamming parity bits plus the overall parity bit p0.
   function automatic int unsigned parity_bits(input int unsigned data_w);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < data_w + r + 1) r++;
      return r + 1;
   endfunction

   function automatic int unsigned code_width(input int unsigned data_w);
      return data_w + parity_bits(data_w);
   endfunction

   // Code position of data bit idx: the idx-th non-power-of-two position above 2.
   function automatic int unsigned data_pos(input int unsigned idx);
      int unsigned n;
      int unsigned res;
      n = 0;
      res = 0;
      for (int unsigned pos = 3; pos < 64; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (n == idx) res = pos;
            n++;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/secded_codec.sv
// Combinational Hamming SECDED encoder and syndrome-based single-error corrector.
module secded_codec import secded_pkg::*; #(
   parameter int unsigned DATA_W = 11,
   localparam int unsigned CODE_W = code_width(DATA_W)
) (
   input  logic [DATA_W-1:0] data,
   input  logic [CODE_W-1:0] code,
   output logic [CODE_W-1:0] enc,
   output logic [DATA_W-1:0] dec_data,
   output status_e           status
);

   localparam int unsigned SYN_W = $clog2(CODE_W);

   logic [SYN_W-1:0]  syn;
   logic [CODE_W-1:0] fixed;
   logic              par;

   always_comb begin
      enc = '0;
      par = 1'b0;
      for (int unsigned i = 0; i < DATA_W; i++) enc[SYN_W'(data_pos(i))] = data[i];
      for (int unsigned k = 0; (32'd1 << k) < CODE_W; k++) begin
         par = 1'b0;
         for (int unsigned j = 1; j < CODE_W; j++) begin
            if ((j & (32'd1 << k)) != 0) par = par ^ enc[SYN_W'(j)];
         end
         enc[SYN_W'(32'd1 << k)] = par;
      end
      enc[0] = ^enc[CODE_W-1:1];
   end

   always_comb begin
      syn      = '0;
      fixed    = code;
      status   = stat_ok;
      dec_data = '0;
      for (int unsigned j = 1; j < CODE_W; j++) begin
         if (code[SYN_W'(j)]) syn = syn ^ SYN_W'(j);
      end
      // Odd overall parity means one flip; syndrome 0 then points at p0 itself.
      if (^code) begin
         fixed[syn] = ~fixed[syn];
         status     = stat_single;
      end else if (syn != '0) begin
         status = stat_double;
      end
      for (int unsigned i = 0; i < DATA_W; i++) dec_data[i] = fixed[SYN_W'(data_pos(i))];
   end

endmodule

// File: rtl/secded_batch_engine.sv
// Batch SECDED encode/decode engine on the byte-wide data-memory port.
// Define SECDED_STATS_EN to build the corrected/uncorrectable word counters.
module secded_batch_engine import secded_pkg::*; #(
   parameter int unsigned DATA_W    = 11,
   parameter int unsigned MSG_COUNT = 15,
   parameter int unsigned SRC_BASE  = 0,
   parameter int unsigned DST_BASE  = 30,
   parameter int unsigned ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_rd_data,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_data,
   output logic [7:0]        err_single,
   output logic [7:0]        err_double
);

   localparam int unsigned CODE_W    = code_width(DATA_W);
   localparam int unsigned BYTES     = CODE_W / 8;
   localparam logic [2:0]  LAST_BYTE = 3'(BYTES);
   localparam logic [6:0]  LAST_WORD = 7'(MSG_COUNT - 1);

   state_e            state_q;
   logic              mode_q;
   logic [2:0]        byte_q;
   logic [6:0]        word_cnt_q;
   logic [CODE_W-1:0] buf_q;
   logic [CODE_W-1:0] out_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W-1:0] wr_ptr_q;

   logic [CODE_W-1:0] enc;
   logic [CODE_W-1:0] code_shift;
   logic [CODE_W-1:0] result;
   logic [DATA_W-1:0] dec_data;
   status_e           status;

   secded_codec #(.DATA_W(DATA_W)) u_codec (
      .data     (buf_q[DATA_W-1:0]),
      .code     (buf_q),
      .enc      (enc),
      .dec_data (dec_data),
      .status   (status)
   );

   // Bytes arrive LSB first, so each capture shifts the word down by one byte.
   always_comb begin
      code_shift = CODE_W'({mem_rd_data, buf_q} >> 8);
      result     = '0;
      if (mode_q) begin
         result[CODE_W-1 -: 2] = status;
         result[DATA_W-1:0]    = dec_data;
      end else begin
         result = enc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= st_idle;
         mode_q      <= 1'b0;
         byte_q      <= '0;
         word_cnt_q  <= '0;
         buf_q       <= '0;
         out_q       <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_addr    <= '0;
         mem_rd_en   <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_wr_data <= '0;
`ifdef SECDED_STATS_EN
         err_single  <= '0;
         err_double  <= '0;
`endif
      end else begin
         case (state_q)
            st_idle: begin
               if (start) begin
                  state_q    <= st_rd;
                  mode_q     <= mode;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  byte_q     <= '0;
                  word_cnt_q <= '0;
                  mem_rd_en  <= 1'b1;
                  mem_addr   <= ADDR_W'(SRC_BASE);
                  rd_ptr_q   <= ADDR_W'(SRC_BASE + 1);
                  wr_ptr_q   <= ADDR_W'(DST_BASE);
`ifdef SECDED_STATS_EN
                  err_single <= '0;
                  err_double <= '0;
`endif
               end
            end
            st_rd: begin
               byte_q <= byte_q + 3'd1;
               if (byte_q != '0) buf_q <= code_shift;
               if (byte_q + 3'd1 < LAST_BYTE) begin
                  mem_rd_en <= 1'b1;
                  mem_addr  <= rd_ptr_q;
                  rd_ptr_q  <= rd_ptr_q + 1'b1;
               end else begin
                  mem_rd_en <= 1'b0;
                  mem_addr  <= '0;
               end
               if (byte_q == LAST_BYTE) begin
                  state_q <= st_calc;
                  byte_q  <= '0;
               end
            end
            st_calc: begin
               out_q       <= result >> 8;
               mem_wr_en   <= 1'b1;
               mem_wr_data <= result[7:0];
               mem_addr    <= wr_ptr_q;
               wr_ptr_q    <= wr_ptr_q + 1'b1;
               byte_q      <= 3'd1;
               state_q     <= st_wr;
`ifdef SECDED_STATS_EN
               if (mode_q && status == stat_single && err_single != 8'hff) begin
                  err_single <= err_single + 8'd1;
               end
               if (mode_q && status == stat_double && err_double != 8'hff) begin
                  err_double <= err_double + 8'd1;
               end
`endif
            end
            st_wr: begin
               if (byte_q < LAST_BYTE) begin
                  mem_wr_data <= out_q[7:0];
                  out_q       <= out_q >> 8;
                  mem_addr    <= wr_ptr_q;
                  wr_ptr_q    <= wr_ptr_q + 1'b1;
                  byte_q      <= byte_q + 3'd1;
               end else begin
                  mem_wr_en <= 1'b0;
                  byte_q    <= '0;
                  if (word_cnt_q == LAST_WORD) begin
                     state_q  <= st_done;
                     mem_addr <= '0;
                  end else begin
                     word_cnt_q <= word_cnt_q + 7'd1;
                     state_q    <= st_rd;
                     mem_rd_en  <= 1'b1;
                     mem_addr   <= rd_ptr_q;
                     rd_ptr_q   <= rd_ptr_q + 1'b1;
                  end
               end
            end
            st_done: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= st_idle;
            end
            default: state_q <= st_idle;
         endcase
      end
   end

`ifndef SECDED_STATS_EN
   assign err_single = '0;
   assign err_double = '0;
`endif

endmodule

// File: tb/tb_secded_batch_engine.sv
// Self-checking bench for secded_batch_engine against a behavioural SECDED model.
module tb_secded_batch_engine;

   localparam int N   = 15;
   localparam int SRC = 0;
   localparam int DST = 30;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       mode;
   logic       busy;
   logic       done;
   logic [7:0] mem_addr;
   logic       mem_rd_en;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;
   logic [7:0] err_single;
   logic [7:0] err_double;

   logic [7:0]  src_mem [256];
   logic [7:0]  dst_mem [256];
   logic [15:0] words [N];
   int          exp_a [$];
   logic [7:0]  exp_d [$];
   int          exp_single;
   int          exp_double;
   logic        no_write = 1'b0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   secded_batch_engine dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mode        (mode),
      .busy        (busy),
      .done        (done),
      .mem_addr    (mem_addr),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data),
      .err_single  (err_single),
      .err_double  (err_double)
   );

   // Synchronous memory: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= src_mem[mem_addr];
      if (mem_wr_en) dst_mem[mem_addr] <= mem_wr_data;
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit is_pow2(input int v);
      return (v & (v - 1)) == 0;
   endfunction

   // Data fills non-power positions; check bits are chosen so the syndrome is 0.
   function automatic logic [15:0] ref_encode(input logic [10:0] d);
      logic [15:0] c;
      logic [3:0]  s;
      int          n;
      c = '0;
      s = '0;
      n = 0;
      for (int pos = 3; pos < 16; pos++) begin
         if (!is_pow2(pos)) begin
            c[4'(pos)] = d[4'(n)];
            if (d[4'(n)]) s = s ^ 4'(pos);
            n++;
         end
      end
      for (int k = 0; k < 4; k++) c[4'(1 << k)] = s[2'(k)];
      c[0] = ^c[15:1];
      return c;
   endfunction

   function automatic logic [15:0] ref_decode(input logic [15:0] cw);
      logic [15:0] c;
      logic [3:0]  s;
      logic [10:0] d;
      logic [1:0]  st;
      int          n;
      c  = cw;
      s  = '0;
      d  = '0;
      st = 2'b00;
      n  = 0;
      for (int pos = 1; pos < 16; pos++) if (c[4'(pos)]) s = s ^ 4'(pos);
      if (^c) begin
         c  = c ^ (16'd1 << s);
         st = 2'b01;
      end else if (s != 0) begin
         st = 2'b10;
      end
      for (int pos = 3; pos < 16; pos++) begin
         if (!is_pow2(pos)) begin
            d[4'(n)] = c[4'(pos)];
            n++;
         end
      end
      return {st, 3'b000, d};
   endfunction

   function automatic logic [15:0] dst_word(input int i);
      return {dst_mem[DST + 2 * i + 1], dst_mem[DST + 2 * i]};
   endfunction

   function automatic logic [15:0] flip_rand(input logic [15:0] w, input int k);
      int b1;
      int b2;
      b1 = int'($urandom_range(0, 15));
      b2 = (b1 + 1 + int'($urandom_range(0, 14))) % 16;
      if (k >= 1) w = w ^ (16'd1 << b1);
      if (k == 2) w = w ^ (16'd1 << b2);
      return w;
   endfunction

   // Compare process: every write against the model's queue, plus bus invariants.
   always @(negedge clk) begin
      if (mem_rd_en && mem_wr_en) check("rd_wr_exclusive", 1, 0);
      if (!busy) check("idle_addr", int'(mem_addr), 0);
      if (mem_rd_en) check("rd_range", int'(mem_addr >= SRC && mem_addr < SRC + 2 * N), 1);
      if (mem_wr_en) begin
         check("wr_range", int'(mem_addr >= DST && mem_addr < DST + 2 * N), 1);
         if (no_write) begin
            check("write_after_reset", 1, 0);
         end else if (exp_a.size() == 0) begin
            check("unexpected_write", int'(mem_addr), -1);
         end else begin
            check("wr_addr", int'(mem_addr), exp_a.pop_front());
            check("wr_data", int'(mem_wr_data), int'(exp_d.pop_front()));
         end
      end
   end

   task automatic run_batch(input logic m, input int glitch, input int abort);
      logic [15:0] w;
      int          n;
      exp_a.delete();
      exp_d.delete();
      exp_single = 0;
      exp_double = 0;
      for (int i = 0; i < N; i++) begin
         src_mem[SRC + 2 * i]     = words[i][7:0];
         src_mem[SRC + 2 * i + 1] = words[i][15:8];
         w = m ? ref_decode(words[i]) : ref_encode(words[i][10:0]);
         if (m && w[15:14] == 2'b01) exp_single++;
         if (m && w[15:14] == 2'b10) exp_double++;
         exp_a.push_back(DST + 2 * i);
         exp_d.push_back(w[7:0]);
         exp_a.push_back(DST + 2 * i + 1);
         exp_d.push_back(w[15:8]);
      end
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      @(posedge clk);
      #1;
      start = 1'b0;
      mode  = ~m;
      check("start_busy", int'(busy), 1);
      check("start_done", int'(done), 0);
      n = 0;
      while (n < 400) begin
         @(posedge clk);
         n++;
         #1;
         start = (n == glitch);
         if (n == abort || done) break;
      end
      start = 1'b0;
      if (n == abort) begin
         reset = 1'b1;
         #1;
         check("abort_busy", int'(busy), 0);
         check("abort_done", int'(done), 0);
         check("abort_wr_en", int'(mem_wr_en), 0);
         no_write = 1'b1;
         repeat (4) @(posedge clk);
         @(negedge clk);
         reset = 1'b0;
         repeat (10) @(negedge clk);
         check("post_abort_busy", int'(busy), 0);
         check("post_abort_done", int'(done), 0);
         no_write = 1'b0;
         exp_a.delete();
         exp_d.delete();
      end else begin
         check("done_cycle", n, 6 * N + 1);
         check("end_busy", int'(busy), 0);
         check("end_done", int'(done), 1);
         check("leftover_writes", exp_a.size(), 0);
         check("end_addr", int'(mem_addr), 0);
`ifdef SECDED_STATS_EN
         check("err_single", int'(err_single), exp_single);
         check("err_double", int'(err_double), exp_double);
`else
         check("err_single", int'(err_single), 0);
         check("err_double", int'(err_double), 0);
`endif
      end
   endtask

   task automatic rand_encode_words();
      for (int i = 0; i < N; i++) words[i] = {5'b0, 11'($urandom)};
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_addr", int'(mem_addr), 0);
      check("rst_rd_en", int'(mem_rd_en), 0);
      check("rst_wr_en", int'(mem_wr_en), 0);
      check("rst_wr_data", int'(mem_wr_data), 0);
      check("rst_err_single", int'(err_single), 0);
      check("rst_err_double", int'(err_double), 0);
      @(negedge clk);
      reset = 1'b0;

      rand_encode_words();
      words[0] = 16'h0000;
      words[1] = 16'h07FF;
      words[2] = 16'h0001;
      run_batch(1'b0, -1, -1);
      check("enc_000", int'(dst_word(0)), 16'h0000);
      check("enc_7ff", int'(dst_word(1)), 16'hFFFF);
      check("enc_001", int'(dst_word(2)), 16'h000F);

      words[0] = 16'h020F;
      words[1] = 16'h000E;
      words[2] = 16'h060F;
      words[3] = 16'h000F;
      words[4] = ref_encode(11'($urandom)) ^ 16'h0008;
      words[5] = ref_encode(11'($urandom)) ^ 16'h0060;
      for (int i = 6; i < N; i++) words[i] = ref_encode(11'($urandom));
      run_batch(1'b1, -1, -1);
      check("dec_020f", int'(dst_word(0)), 16'h4001);
      check("dec_000e", int'(dst_word(1)), 16'h4001);
      check("dec_060f", int'(dst_word(2)), 16'h8031);
      check("dec_000f", int'(dst_word(3)), 16'h0001);
`ifdef SECDED_STATS_EN
      check("lit_err_single", int'(err_single), 3);
      check("lit_err_double", int'(err_double), 2);
`endif

      for (int r = 0; r < 2; r++) begin
         rand_encode_words();
         run_batch(1'b0, -1, -1);
      end
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) begin
            words[i] = flip_rand(ref_encode(11'($urandom)), int'($urandom_range(0, 2)));
         end
         run_batch(1'b1, -1, -1);
      end

      rand_encode_words();
      run_batch(1'b0, -1, 40);
      rand_encode_words();
      run_batch(1'b0, -1, -1);

      rand_encode_words();
      run_batch(1'b0, 20, -1);

      check("done_held", int'(done), 1);
      for (int i = 0; i < N; i++) begin
         words[i] = flip_rand(ref_encode(11'($urandom)), int'($urandom_range(0, 2)));
      end
      run_batch(1'b1, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
